// File: rtl/vector_unpacker_if.sv
// Handshake bundle for vector_unpacker: vector load side plus lane-beat stream side.
// The overrun flag exists only when VUNPACK_OVERRUN_EN is defined.
interface vector_unpacker_if #(
  parameter int unsigned LANES = 4,
  parameter int unsigned W     = 8
);
  localparam int unsigned IdxW = (LANES > 1) ? $clog2(LANES) : 1;

  logic                 load;
  logic [LANES*W-1:0]   vec_in;
  logic                 busy;
  logic                 out_valid;
  logic                 out_ready;
  logic [W-1:0]         out_data;
  logic [IdxW-1:0]      out_idx;
  logic                 out_last;
  logic                 done;
`ifdef VUNPACK_OVERRUN_EN
  logic                 overrun;

  modport master (
    input  load, vec_in, out_ready,
    output busy, out_valid, out_data, out_idx, out_last, done, overrun
  );
  modport slave (
    output load, vec_in, out_ready,
    input  busy, out_valid, out_data, out_idx, out_last, done, overrun
  );
`else
  modport master (
    input  load, vec_in, out_ready,
    output busy, out_valid, out_data, out_idx, out_last, done
  );
  modport slave (
    output load, vec_in, out_ready,
    input  busy, out_valid, out_data, out_idx, out_last, done
  );
`endif
endinterface

// File: rtl/vector_unpacker.sv
// Captures a packed LANES*W vector and emits it lane by lane over a valid/ready stream.
// Optional sticky overrun flag for loads ignored while busy: define VUNPACK_OVERRUN_EN.
module vector_unpacker #(
  parameter int unsigned LANES = 4,
  parameter int unsigned W     = 8
) (
  input  logic              clk,
  input  logic              reset,
  vector_unpacker_if.master bus
);
  localparam int unsigned IdxW = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(LANES - 1);

  typedef enum logic [1:0] {StIdle, StSend, StDone} state_e;

  state_e             state_q, state_d;
  logic [IdxW-1:0]    idx_q, idx_d;
  logic [LANES*W-1:0] shadow_q, shadow_d;
  logic               send;

  // All state advances on the falling edge of clk.
  always_ff @(negedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      idx_q    <= '0;
      shadow_q <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      shadow_q <= shadow_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    shadow_d = shadow_q;
    unique case (state_q)
      StIdle: begin
        if (bus.load) begin
          shadow_d = bus.vec_in;
          idx_d    = '0;
          state_d  = StSend;
        end
      end
      StSend: begin
        if (bus.out_ready) begin
          if (idx_q == LastIdx) begin
            idx_d   = '0;
            state_d = StDone;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs are decoded purely from registered state.
  always_comb begin
    send          = (state_q == StSend);
    bus.out_valid = send;
    bus.out_data  = send ? shadow_q[32'(idx_q) * W +: W] : '0;
    bus.out_idx   = idx_q;
    bus.out_last  = send && (idx_q == LastIdx);
    bus.busy      = (state_q != StIdle);
    bus.done      = (state_q == StDone);
  end

`ifdef VUNPACK_OVERRUN_EN
  logic overrun_q;

  always_ff @(negedge clk or posedge reset) begin
    if (reset) begin
      overrun_q <= 1'b0;
    end else if (bus.load && (state_q != StIdle)) begin
      overrun_q <= 1'b1;
    end
  end

  assign bus.overrun = overrun_q;
`endif
endmodule
